// File: rtl/comb_param_mc.sv
// comb_param_mc: multi-channel CIC comb, y[n] = x[n] - x[n-M] per channel.
// Channels are time-interleaved and tagged by tuser. The differential delay M
// is set at runtime, and the delay line is zero-primed. The block supports full
// AXI-stream backpressure through a single pipeline enable.
// Optional feature macro: COMB_SAT_EN. When defined, the output saturates and a
// sticky overflow flag is provided. When undefined, the output is modular and
// overflow is tied to 0.
module comb_param_mc #(
    parameter int DATA_WIDTH = 48,
    parameter int ADDR_WIDTH = 8,
    parameter int CHAN_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  async_reset_n,
    input  logic [ADDR_WIDTH:0]   msetting,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHAN_WIDTH-1:0] s_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [CHAN_WIDTH-1:0] m_axis_tuser,
    output logic                  overflow
);

    localparam int NUM_CHAN  = 2 ** CHAN_WIDTH;
    localparam int MMAX      = 2 ** ADDR_WIDTH;
    localparam int RAM_DEPTH = NUM_CHAN * MMAX;
    localparam logic [ADDR_WIDTH:0] MMAX_W = (ADDR_WIDTH + 1)'(MMAX);
    localparam logic [ADDR_WIDTH:0] ONE_W  = (ADDR_WIDTH + 1)'(1);

`ifdef COMB_SAT_EN
    function automatic logic signed [DATA_WIDTH:0] full_diff(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
    endfunction

    // The result does not fit in DATA_WIDTH when the two top bits disagree.
    function automatic logic clip_fn(input logic signed [DATA_WIDTH:0] v);
        return v[DATA_WIDTH] != v[DATA_WIDTH-1];
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_fn(input logic signed [DATA_WIDTH:0] v);
        if (v[DATA_WIDTH] != v[DATA_WIDTH-1]) begin
            return v[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return v[DATA_WIDTH-1:0];
    endfunction
`else
    // A DATA_WIDTH-bit modular difference equals the DATA_WIDTH+1 result truncated.
    function automatic logic signed [DATA_WIDTH-1:0] wrap_fn(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return a - b;
    endfunction
`endif

    // Reset synchroniser: assertion is immediate, deassertion is clean.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    // Control state.
    logic [ADDR_WIDTH:0]   m_eff, m_reg_q, m_reg_d;
    logic                  retune, en, accept, primed_in;
    logic [ADDR_WIDTH-1:0] ptr_q  [NUM_CHAN];
    logic [ADDR_WIDTH-1:0] ptr_d  [NUM_CHAN];
    logic [ADDR_WIDTH:0]   fill_q [NUM_CHAN];
    logic [ADDR_WIDTH:0]   fill_d [NUM_CHAN];
    logic [ADDR_WIDTH-1:0] cur_ptr;
    logic [ADDR_WIDTH:0]   cur_fill;
    logic [CHAN_WIDTH+ADDR_WIDTH-1:0] ram_addr;

    // Delay-line storage.
    logic signed [DATA_WIDTH-1:0] ram_q [RAM_DEPTH];
    logic signed [DATA_WIDTH-1:0] ram_rd_q, ram_rd_d;

    // Pipeline registers.
    logic                         vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
    logic signed [DATA_WIDTH-1:0] x_p1_q, x_p1_d, x_p2_q, x_p2_d;
    logic [CHAN_WIDTH-1:0]        c_p1_q, c_p1_d, c_p2_q, c_p2_d, c_p3_q, c_p3_d;
    logic                         primed_p1_q, primed_p1_d, primed_p2_q, primed_p2_d;
    logic signed [DATA_WIDTH-1:0] ramd_p2_q, ramd_p2_d;
    logic signed [DATA_WIDTH-1:0] y_p3_q, y_p3_d, y_calc, hist_p2;
`ifdef COMB_SAT_EN
    logic signed [DATA_WIDTH:0]   diff_p2;
    logic                         clip_p2;
    logic                         overflow_q, overflow_d;
`endif

    // Shift a constant one through the synchroniser.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    // The synchroniser flops clear asynchronously from the external reset.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) rst_sync_q <= '0;
        else                rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // Clamp msetting to 1..Mmax. Any change of the effective value is a retune.
    always_comb begin
        m_eff = msetting;
        if (msetting == '0)          m_eff = ONE_W;
        else if (msetting > MMAX_W)  m_eff = MMAX_W;
        m_reg_d = m_eff;
        retune  = (m_eff != m_reg_q);
    end

    // Handshake, addressing and priming for the sample presented this cycle.
    always_comb begin
        en        = ~vld_p3_q | m_axis_tready;
        accept    = s_axis_tvalid & en;
        cur_ptr   = ptr_q[s_axis_tuser];
        cur_fill  = fill_q[s_axis_tuser];
        primed_in = (cur_fill == m_reg_q);
        ram_addr  = {s_axis_tuser, cur_ptr};
    end

    // Per-channel pointer/fill update. A retune clear wins over the accept update.
    always_comb begin
        for (int i = 0; i < NUM_CHAN; i++) begin
            ptr_d[i]  = ptr_q[i];
            fill_d[i] = fill_q[i];
            if (retune) begin
                ptr_d[i]  = '0;
                fill_d[i] = '0;
            end else if (accept && (s_axis_tuser == CHAN_WIDTH'(i))) begin
                ptr_d[i] = ({1'b0, ptr_q[i]} == (m_reg_q - ONE_W)) ? '0 : ptr_q[i] + ADDR_WIDTH'(1);
                if (fill_q[i] < m_reg_q) fill_d[i] = fill_q[i] + ONE_W;
            end
        end
    end

    // Compute the comb difference from the S2 contents. Unprimed history reads as zero.
    always_comb begin
        hist_p2 = primed_p2_q ? ramd_p2_q : '0;
`ifdef COMB_SAT_EN
        diff_p2    = full_diff(x_p2_q, hist_p2);
        y_calc     = sat_fn(diff_p2);
        clip_p2    = clip_fn(diff_p2);
        overflow_d = overflow_q | (en & vld_p2_q & clip_p2);
`else
        y_calc = wrap_fn(x_p2_q, hist_p2);
`endif
    end

    // Advance all stages together on en. Otherwise every stage holds its value.
    always_comb begin
        vld_p1_d    = vld_p1_q;
        x_p1_d      = x_p1_q;
        c_p1_d      = c_p1_q;
        primed_p1_d = primed_p1_q;
        ram_rd_d    = ram_rd_q;
        vld_p2_d    = vld_p2_q;
        x_p2_d      = x_p2_q;
        c_p2_d      = c_p2_q;
        primed_p2_d = primed_p2_q;
        ramd_p2_d   = ramd_p2_q;
        vld_p3_d    = vld_p3_q;
        y_p3_d      = y_p3_q;
        c_p3_d      = c_p3_q;
        if (en) begin
            // S1: capture sample, channel and priming; the RAM read is issued.
            vld_p1_d    = s_axis_tvalid;
            x_p1_d      = s_axis_tdata;
            c_p1_d      = s_axis_tuser;
            primed_p1_d = primed_in;
            ram_rd_d    = ram_q[ram_addr];
            // S2: register the RAM data alongside the delayed sample.
            vld_p2_d    = vld_p1_q;
            x_p2_d      = x_p1_q;
            c_p2_d      = c_p1_q;
            primed_p2_d = primed_p1_q;
            ramd_p2_d   = ram_rd_q;
            // S3: register the output.
            vld_p3_d    = vld_p2_q;
            y_p3_d      = y_calc;
            c_p3_d      = c_p2_q;
        end
    end

    // Control and output registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg_q <= ONE_W;
            for (int i = 0; i < NUM_CHAN; i++) begin
                ptr_q[i]  <= '0;
                fill_q[i] <= '0;
            end
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            y_p3_q   <= '0;
            c_p3_q   <= '0;
`ifdef COMB_SAT_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            m_reg_q <= m_reg_d;
            for (int i = 0; i < NUM_CHAN; i++) begin
                ptr_q[i]  <= ptr_d[i];
                fill_q[i] <= fill_d[i];
            end
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            y_p3_q   <= y_p3_d;
            c_p3_q   <= c_p3_d;
`ifdef COMB_SAT_EN
            overflow_q <= overflow_d;
`endif
        end
    end

    // Internal data path registers. Their contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        x_p1_q      <= x_p1_d;
        c_p1_q      <= c_p1_d;
        primed_p1_q <= primed_p1_d;
        ram_rd_q    <= ram_rd_d;
        x_p2_q      <= x_p2_d;
        c_p2_q      <= c_p2_d;
        primed_p2_q <= primed_p2_d;
        ramd_p2_q   <= ramd_p2_d;
    end

    // Read-first write port. The same-cycle read above returns the old word.
    always_ff @(posedge clk) begin
        if (accept) ram_q[ram_addr] <= s_axis_tdata;
    end

    assign s_axis_tready = en;
    assign m_axis_tvalid = vld_p3_q;
    assign m_axis_tdata  = y_p3_q;
    assign m_axis_tuser  = c_p3_q;
`ifdef COMB_SAT_EN
    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_comb_param_mc.sv
// Scoreboard bench for comb_param_mc. The reference model keeps a history
// queue per channel and computes x[n] - x[n-M] arithmetically.
module tb_comb_param_mc;

    localparam int DW = 48;
    localparam int AW = 8;
    localparam int CW = 2;
    localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (DW - 1));

    logic          clk = 1'b0;
    logic          async_reset_n;
    logic [AW:0]   msetting;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [CW-1:0] s_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [CW-1:0] m_axis_tuser;
    logic          overflow;

    always #5 clk = ~clk;

    comb_param_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHAN_WIDTH(CW)) dut (
        .clk(clk), .async_reset_n(async_reset_n), .msetting(msetting),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
        .overflow(overflow)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] u;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model state.
    logic signed [DW-1:0] hist [4][$];
    int          cur_m = 1;
    bit          pend = 0;
    int          pend_m = 1;
    bit          mreq = 0;
    logic [AW:0] mreq_val = '0;
    bit          exp_ovf = 0;

    bit rand_rdy = 0;
    bit lat_drv = 0, lat_arm = 0;
    int acc_cyc = 0, out_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int eff_m(input int v);
        if (v == 0) return 1;
        if (v > 256) return 256;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) hist[c].delete();
    endtask

    task automatic apply_pending();
        if (pend) begin
            if (pend_m != cur_m) model_clear();
            cur_m = pend_m;
            pend  = 0;
        end
    endtask

    task automatic take_mreq();
        if (mreq) begin
            msetting = mreq_val;
            mreq     = 0;
            pend     = 1;
            pend_m   = eff_m(int'(mreq_val));
        end
    endtask

    // y = x - x[n-M] with zero history, then wrap or clip to DW bits.
    task automatic model_accept(input int c, input logic signed [DW-1:0] x);
        int n;
        longint xl, ol, f;
        logic signed [DW-1:0] old;
        exp_t e;
        n   = hist[c].size();
        old = (n >= cur_m) ? hist[c][n - cur_m] : '0;
        xl  = x;
        ol  = old;
        f   = xl - ol;
`ifdef COMB_SAT_EN
        if (f > MAXV) begin
            f = MAXV;
            exp_ovf = 1;
        end else if (f < MINV) begin
            f = MINV;
            exp_ovf = 1;
        end
`endif
        e.d = DW'(f);
        e.u = CW'(c);
        exp_q.push_back(e);
        hist[c].push_back(x);
        if (hist[c].size() > 256) void'(hist[c].pop_front());
        apply_pending();
    endtask

    task automatic send(input int c, input logic [DW-1:0] x);
        int guard;
        @(negedge clk);
        take_mreq();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = x;
        s_axis_tuser  = CW'(c);
        #1;
        guard = 0;
        while (!s_axis_tready && guard < 1000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=stalled required=accepted");
        end
        if (lat_drv) begin
            acc_cyc = cyc;
            lat_drv = 0;
        end
        model_accept(c, x);
    endtask

    task automatic idle();
        @(negedge clk);
        take_mreq();
        s_axis_tvalid = 1'b0;
        apply_pending();
    endtask

    task automatic drain();
        int guard;
        idle();
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset(input logic [AW:0] mset);
        @(negedge clk);
        #3;
        s_axis_tvalid = 1'b0;
        async_reset_n = 1'b0;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_overflow", overflow, 0);
        exp_q.delete();
        model_clear();
        exp_ovf  = 0;
        pend     = 0;
        mreq     = 0;
        msetting = mset;
        repeat (3) @(negedge clk);
        async_reset_n = 1'b1;
        repeat (5) @(negedge clk);
        cur_m = eff_m(int'(mset));
    endtask

    // Downstream ready: always ready, or a 50% random pattern.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            m_axis_tready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: check the ready rule every cycle; pop and compare on each handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (async_reset_n === 1'b1) begin
                total++;
                if (s_axis_tready !== (~m_axis_tvalid | m_axis_tready)) begin
                    bad++;
                    $display("FAIL tready_rule actual=%b required=%b", s_axis_tready,
                             ~m_axis_tvalid | m_axis_tready);
                end
                if (lat_arm && m_axis_tvalid) begin
                    out_cyc = cyc;
                    lat_arm = 0;
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_output actual=%0h/%0d required=none", m_axis_tdata, m_axis_tuser);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_axis_tdata !== e.d || m_axis_tuser !== e.u) begin
                            bad++;
                            $display("FAIL out_sample actual=%0h/ch%0d required=%0h/ch%0d",
                                     m_axis_tdata, m_axis_tuser, e.d, e.u);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] r;
        async_reset_n = 1'b0;
        msetting      = 1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tuser  = '0;

        // Impulse response, M=4, plus first-output latency.
        do_reset(4);
        lat_drv = 1;
        lat_arm = 1;
        send(0, 5);
        for (int i = 0; i < 5; i++) send(0, 0);
        drain();
        chk("latency", out_cyc - acc_cyc, 3);

        // Priming, M=8, constant input.
        do_reset(8);
        for (int i = 0; i < 20; i++) send(0, 100);
        drain();

        // Four interleaved channels, M=2, round-robin.
        do_reset(2);
        for (int n = 0; n < 8; n++)
            for (int c = 0; c < 4; c++) send(c, DW'(c * 10 + n));
        drain();

        // Backpressure with a ramp, then random data with bubbles; ended by a mid-stream reset.
        do_reset(3);
        rand_rdy = 1;
        for (int i = 0; i < 48; i++) send($urandom_range(0, 3), DW'(i));
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            r = {$urandom(), $urandom()};
            send($urandom_range(0, 3), r[DW-1:0]);
        end
        rand_rdy = 0;

        // Retune: 4 -> 6 across a bubble, 6 -> 0 and 0 -> 300 coinciding with accepts.
        do_reset(4);
        for (int n = 0; n < 10; n++) send(n % 2, DW'(1000 + 3 * n * n));
        mreq = 1;
        mreq_val = 6;
        idle();
        idle();
        for (int n = 10; n < 34; n++) send(n % 2, DW'(1000 + 3 * n * n));
        mreq = 1;
        mreq_val = 0;
        for (int n = 0; n < 8; n++) send(n % 3, DW'(50 + 7 * n * n));
        mreq = 1;
        mreq_val = 300;
        for (int n = 0; n < 270; n++) begin
            r = {$urandom(), $urandom()};
            send(2, r[DW-1:0]);
        end
        send(3, 77);
        send(3, 78);
        drain();

        // Extreme step with M=1: wraps by default and clips with saturation enabled.
        do_reset(1);
        send(0, 48'h8000_0000_0000);
        send(0, 48'h7FFF_FFFF_FFFF);
        send(0, 48'h7FFF_FFFF_FFFF);
        drain();
        chk("overflow_flag", overflow, exp_ovf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
